// File: rtl/seg_disp_pkg.sv
// Shared definitions for the 7-segment display arbiter.
//   state_e      : arbiter FSM states
//   IDLE_PATTERN : value that display_7seg renders as "----"
//   req_idx_t    : requester index (at most four requesters)
//   cnt_width()  : counter width that can hold 0..max_count-1
//   wrap_idx()   : modulo reduction of an index offset onto the requester range
package seg_disp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StAlarm
    } state_e;

    localparam logic [15:0] IDLE_PATTERN = 16'hFFFF;

    typedef logic [1:0] req_idx_t;

    function automatic int unsigned cnt_width(int unsigned max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

    function automatic req_idx_t wrap_idx(int unsigned val, int unsigned n);
        return req_idx_t'(val % n);
    endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector, bit i = source i
//   rr_ptr : index of the most recent owner; search starts one past it
//   found  : some source is requesting
//   index  : first requesting source at rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ)
// The last candidate examined is rr_ptr itself, so a lone owner can win again.
module seg_rr_pick
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           rr_ptr,
    output logic               found,
    output req_idx_t           index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        // Farthest candidate first so that the nearest requester overwrites it.
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            if (req[wrap_idx(32'(rr_ptr) + k, NUM_REQ)]) begin
                found = 1'b1;
                index = wrap_idx(32'(rr_ptr) + k, NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Shares one 4-digit 7-segment display driver between NUM_REQ data sources.
// Sources are granted round-robin, each for DWELL_CYCLES clocks; an alarm
// request preempts everything and blinks alarm_data with IDLE_PATTERN.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : level request per source
//   req_data     : 16 bits per source, source i at [16i+15:16i]
//   alarm_req    : level alarm request, highest priority
//   alarm_data   : value shown while the alarm is active
//   disp_data    : registered value for display_7seg
//   grant        : one-hot current owner, zero in idle or alarm
//   alarm_active : high while in alarm
//   slot_end     : one-cycle pulse when a dwell period expires
module seg_disp_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned BLINK_CYCLES = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_data,
    input  logic                  alarm_req,
    input  logic [15:0]           alarm_data,
    output logic [15:0]           disp_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  alarm_active,
    output logic                  slot_end
);

    localparam int unsigned DWELL_W = cnt_width(DWELL_CYCLES);
    localparam int unsigned BLINK_W = cnt_width(BLINK_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    state_e               state_q, state_d;
    req_idx_t             rr_ptr_q, rr_ptr_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [15:0]          disp_q, disp_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 alarm_active_q, alarm_active_d;
    logic                 slot_end_q, slot_end_d;

    logic                 pick_found;
    req_idx_t             pick_index;
    logic                 go_show;
    logic [3:0]           req_pad;
    logic [15:0]          src_data [4];

    // Padded to four entries so any 2-bit index stays in range.
    assign req_pad = 4'(req);

    for (genvar i = 0; i < 4; i++) begin : g_src
        if (i < NUM_REQ) begin : g_used
            assign src_data[i] = req_data[16*i +: 16];
        end else begin : g_unused
            assign src_data[i] = IDLE_PATTERN;
        end
    end

    function automatic logic [NUM_REQ-1:0] one_hot(req_idx_t idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        return oh[NUM_REQ-1:0];
    endfunction

    // While in SHOW, rr_ptr_q holds the current owner.
    seg_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found),
        .index  (pick_index)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        dwell_d        = dwell_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        disp_d         = IDLE_PATTERN;
        grant_d        = '0;
        alarm_active_d = 1'b0;
        slot_end_d     = 1'b0;
        go_show        = 1'b0;

        if (alarm_req) begin
            state_d        = StAlarm;
            alarm_active_d = 1'b1;
            if (state_q != StAlarm) begin
                blink_cnt_d   = '0;
                blink_phase_d = 1'b0;
                // Step back one so the preempted owner is the first candidate later.
                if (state_q == StShow) begin
                    rr_ptr_d = wrap_idx(32'(rr_ptr_q) + NUM_REQ - 1, NUM_REQ);
                end
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
            disp_d = blink_phase_d ? IDLE_PATTERN : alarm_data;
        end else begin
            unique case (state_q)
                StIdle: begin
                    go_show = pick_found;
                end
                StShow: begin
                    if (dwell_q == DWELL_LAST) begin
                        slot_end_d = 1'b1;
                        state_d    = StIdle;
                        go_show    = pick_found;
                    end else if (!req_pad[rr_ptr_q]) begin
                        state_d = StIdle;
                        go_show = pick_found;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                        disp_d  = src_data[rr_ptr_q];
                        grant_d = one_hot(rr_ptr_q);
                    end
                end
                StAlarm: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (go_show) begin
                state_d  = StShow;
                rr_ptr_d = pick_index;
                dwell_d  = '0;
                disp_d   = src_data[pick_index];
                grant_d  = one_hot(pick_index);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rr_ptr_q       <= req_idx_t'(NUM_REQ - 1);
            dwell_q        <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            disp_q         <= IDLE_PATTERN;
            grant_q        <= '0;
            alarm_active_q <= 1'b0;
            slot_end_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            dwell_q        <= dwell_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            disp_q         <= disp_d;
            grant_q        <= grant_d;
            alarm_active_q <= alarm_active_d;
            slot_end_q     <= slot_end_d;
        end
    end

    assign disp_data    = disp_q;
    assign grant        = grant_q;
    assign alarm_active = alarm_active_q;
    assign slot_end     = slot_end_q;

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Shares the single 4-digit 7-segment display driver (16-bit hex input, 4 nibbles) between up to 4 data sources. Typical sources are the ADC reading, a setpoint and a counter.
- Grants the display round-robin, holding each grant for a minimum dwell time. A priority alarm channel preempts every source and blinks.
- Sits between the data-producing blocks and display_7seg; disp_data drives that block's data input directly.

Parameters:
- NUM_REQ, 3, number of round-robin requesters; legal range 2..4.
- DWELL_CYCLES, 100_000_000, clk cycles each grant is held (1 s at 100 MHz); must be >= 2.
- BLINK_CYCLES, 25_000_000, half-period of the alarm blink in clk cycles; must be >= 1.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset; asynchronous assert, active-low
- req  in  NUM_REQ  level request per source; bit i = source i
- req_data  in  16*NUM_REQ  source i occupies bits [16i+15:16i]
- alarm_req  in  1  level alarm request; highest priority
- alarm_data  in  16  value shown during an alarm
- disp_data  out  16  registered value fed to the display driver
- grant  out  NUM_REQ  one-hot current owner; all zero in IDLE or ALARM
- alarm_active  out  1  high while in ALARM
- slot_end  out  1  one-cycle pulse when a dwell period expires

Behaviour:
- Reset values (async): state=IDLE, disp_data=16'hFFFF, grant=0, alarm_active=0, slot_end=0, dwell_cnt=0, blink_cnt=0, blink_phase=0, rr_ptr=NUM_REQ-1.
- IDLE_PATTERN = 16'hFFFF; display_7seg renders it as "----".
- All outputs are registered. A decision made in cycle N appears on the outputs in cycle N+1.
- Round-robin pick: search starts at index rr_ptr+1 (mod NUM_REQ) and takes the first i with req[i]=1. rr_ptr updates to the granted index on every new grant.
- FSM states: IDLE, SHOW, ALARM.
- IDLE:
  - alarm_req=1 -> ALARM.
  - else any req -> SHOW with the picked owner; dwell_cnt=0.
  - else stay; disp_data=IDLE_PATTERN.
- SHOW:
  - disp_data follows req_data of the owner live (registered copy each cycle); grant = one-hot owner.
  - dwell_cnt increments each cycle.
  - When dwell_cnt = DWELL_CYCLES-1: slot_end pulses and dwell_cnt=0. Then:
    - another source requesting -> grant the next per round-robin;
    - only the owner requesting -> keep the owner, new slot;
    - none requesting -> IDLE.
  - Owner drops req mid-slot: slot ends next cycle with no slot_end pulse. Next requester per round-robin, else IDLE.
- ALARM:
  - Entered from any state the cycle after alarm_req=1, with blink_cnt=0 and blink_phase=0.
  - The preempted owner's slot is abandoned; rr_ptr is restored to (owner-1) mod NUM_REQ so the preempted source is first candidate afterwards.
  - disp_data = blink_phase ? IDLE_PATTERN : alarm_data; blink_phase toggles every BLINK_CYCLES.
  - alarm_active=1; grant=0.
  - alarm_req=0 -> IDLE, and the next cycle re-arbitrates with a fresh dwell.
- Simultaneous events:
  - alarm_req together with dwell expiry: alarm wins, no slot_end pulse.
  - req rising for a non-owner mid-slot: no effect until the slot ends.
- req_data changes mid-slot are shown one cycle later. There is no latching at grant time.
- rst_n asserted mid-slot or mid-alarm: immediate return to the reset values listed above.

Decomposition:
- Shared package seg_disp_pkg:
  - state enum {IDLE, SHOW, ALARM};
  - IDLE_PATTERN 16'hFFFF;
  - the width function for counters, clog2 of the DWELL_CYCLES and BLINK_CYCLES maxima.
- Natural sub-module: seg_rr_pick. It is combinational; inputs req and rr_ptr, outputs found and index. It is reused by the IDLE entry and slot-end paths.

Test Plan (DWELL_CYCLES=8, BLINK_CYCLES=4, NUM_REQ=3):
- Reset, no req -> disp_data=16'hFFFF, grant=000, alarm_active=0 held for 20 cycles.
- req=111, data 16'h1111/16'h2222/16'h3333 -> grant 001,010,100,001 changing every 8 cycles. disp_data follows the owner; slot_end pulses once per slot.
- req=010 only for 30 cycles -> grant stays 010 and slot_end pulses every 8 cycles. Drop req[1] at cycle 3 of a slot -> next cycle IDLE, disp_data=FFFF, no slot_end.
- Owner 0 at cycle 5 of a slot, alarm_req=1 with alarm_data=16'hE001 for 12 cycles -> disp_data E001 x4, FFFF x4, E001 x4; alarm_active=1; grant=000. After release -> grant 001 (fresh dwell), not 010.
- alarm_req rises on the same cycle as dwell expiry -> ALARM entered and no slot_end pulse.
- rst_n pulsed low mid-ALARM -> asynchronous return to the reset values; after release, normal arbitration resumes from index 0.
